id_stage_pipe: RTL and testbench

ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

---
 rtl/id_stage_pipe_pkg.sv | 58 +++++
 rtl/id_stage_pipe_hazard_unit.sv | 39 +++
 rtl/id_stage_pipe.sv | 194 +++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pipe_pkg.sv
// Shared ISA constants for the decode stage: opcodes, EXE commands,
// branch kinds and the control bundle carried into EXE.
package id_stage_pipe_pkg;

    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd3;
    localparam logic [5:0] OP_AND  = 6'd5;
    localparam logic [5:0] OP_OR   = 6'd6;
    localparam logic [5:0] OP_NOR  = 6'd7;
    localparam logic [5:0] OP_XOR  = 6'd8;
    localparam logic [5:0] OP_SLA  = 6'd9;
    localparam logic [5:0] OP_SLL  = 6'd10;
    localparam logic [5:0] OP_SRA  = 6'd11;
    localparam logic [5:0] OP_SRL  = 6'd12;
    localparam logic [5:0] OP_ADDI = 6'd32;
    localparam logic [5:0] OP_SUBI = 6'd33;
    localparam logic [5:0] OP_LD   = 6'd36;
    localparam logic [5:0] OP_ST   = 6'd37;
    localparam logic [5:0] OP_BEZ  = 6'd40;
    localparam logic [5:0] OP_BNE  = 6'd41;
    localparam logic [5:0] OP_JMP  = 6'd42;

    // EXE_NOP must stay zero so a bubble is indistinguishable from a NOP.
    localparam logic [3:0] EXE_NOP = 4'd0;
    localparam logic [3:0] EXE_ADD = 4'd1;
    localparam logic [3:0] EXE_SUB = 4'd2;
    localparam logic [3:0] EXE_AND = 4'd3;
    localparam logic [3:0] EXE_OR  = 4'd4;
    localparam logic [3:0] EXE_NOR = 4'd5;
    localparam logic [3:0] EXE_XOR = 4'd6;
    localparam logic [3:0] EXE_SHL = 4'd7;
    localparam logic [3:0] EXE_SRA = 4'd8;
    localparam logic [3:0] EXE_SRL = 4'd9;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_BEZ  = 2'd1,
        BR_BNE  = 2'd2,
        BR_JMP  = 2'd3
    } br_type_e;

    typedef struct packed {
        logic [3:0] exe_cmd;
        logic       mem_r_en;
        logic       mem_w_en;
        logic       wb_en;
    } ctrl_t;

    typedef struct packed {
        logic     is_immediate;
        logic     st_or_bne;
        logic     is_branch_or_jump;
        br_type_e branch_type;
        ctrl_t    ctrl;
    } dec_t;

endpackage

// File: rtl/id_stage_pipe_hazard_unit.sv
// Read-after-write hazard detection for the decode stage.
// ID_FORWARDING_EN selects the load-use/branch rule instead of stall-on-any-match.
module id_hazard_unit #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  in_valid,
    input  logic [REG_ADDR_W-1:0] src1,
    input  logic [REG_ADDR_W-1:0] src2,
    input  logic                  use_src1,
    input  logic                  use_src2,
    input  logic                  is_branch,
    input  logic [REG_ADDR_W-1:0] EXE_dest,
    input  logic [REG_ADDR_W-1:0] MEM_dest,
    input  logic                  EXE_WB_en,
    input  logic                  EXE_MEM_R_en,
    input  logic                  MEM_WB_en,
    output logic                  hazard
);

    logic s1_live, s2_live, exe_hit;

    // Register 0 is hard-wired, so it never carries a dependency.
    assign s1_live = use_src1 & (src1 != '0);
    assign s2_live = use_src2 & (src2 != '0);
    assign exe_hit = (s1_live & (src1 == EXE_dest)) | (s2_live & (src2 == EXE_dest));

`ifdef ID_FORWARDING_EN
    // Branches resolve here, before the EXE result can be forwarded to them.
    logic unused_mem;
    assign unused_mem = ^{MEM_dest, MEM_WB_en};
    assign hazard = in_valid & ((exe_hit & EXE_MEM_R_en) | (is_branch & exe_hit & EXE_WB_en));
`else
    logic mem_hit, unused_br;
    assign unused_br = ^{is_branch, EXE_MEM_R_en};
    assign mem_hit = (s1_live & (src1 == MEM_dest)) | (s2_live & (src2 == MEM_dest));
    assign hazard = in_valid & ((exe_hit & EXE_WB_en) | (mem_hit & MEM_WB_en));
`endif

endmodule

// File: rtl/id_stage_pipe.sv
// Instruction decode stage with ID/EXE pipeline register, branch resolution
// and stall counter. Hazard rule chosen by macro ID_FORWARDING_EN.
module id_stage_pipe
    import id_stage_pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           instruction,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [REG_ADDR_W-1:0] src1,
    output logic [REG_ADDR_W-1:0] src2,
    input  logic [DATA_W-1:0]     Reg1,
    input  logic [DATA_W-1:0]     Reg2,
    input  logic [REG_ADDR_W-1:0] EXE_dest,
    input  logic [REG_ADDR_W-1:0] MEM_dest,
    input  logic                  EXE_WB_en,
    input  logic                  EXE_MEM_R_en,
    input  logic                  MEM_WB_en,
    input  logic                  exe_ready,
    input  logic                  flush,
    output logic                  Br_taken,
    output logic                  valid_q,
    output logic [REG_ADDR_W-1:0] dest_q,
    output logic [REG_ADDR_W-1:0] src1_q,
    output logic [REG_ADDR_W-1:0] src2_q,
    output logic [DATA_W-1:0]     Val1_q,
    output logic [DATA_W-1:0]     Val2_q,
    output logic [DATA_W-1:0]     Reg2_q,
    output logic [3:0]            EXE_cmd_q,
    output logic                  MEM_R_en_q,
    output logic                  MEM_W_en_q,
    output logic                  WB_en_q,
    output logic [CNT_W-1:0]      stall_cnt
);

    logic [5:0]            opcode;
    dec_t                  dec;
    logic [REG_ADDR_W-1:0] dest_f;
    logic                  use_src1, use_src2, hazard, advance, cond;
    logic                  valid_d, stall_inc;
    ctrl_t                 ctrl_d;
    logic [DATA_W-1:0]     imm_ext, val2_d;
    logic [REG_ADDR_W-1:0] src1_fwd_d, src2_fwd_d;
    logic [CNT_W-1:0]      stall_cnt_d;

    assign opcode = instruction[31:26];
    assign dest_f = REG_ADDR_W'(instruction[25:21]);
    assign src1   = REG_ADDR_W'(instruction[20:16]);
    assign src2   = dec.st_or_bne ? dest_f : REG_ADDR_W'(instruction[15:11]);

    always_comb begin
        dec = '0;
        case (opcode)
            OP_ADD:  begin dec.ctrl.exe_cmd = EXE_ADD; dec.ctrl.wb_en = 1'b1; end
            OP_SUB:  begin dec.ctrl.exe_cmd = EXE_SUB; dec.ctrl.wb_en = 1'b1; end
            OP_AND:  begin dec.ctrl.exe_cmd = EXE_AND; dec.ctrl.wb_en = 1'b1; end
            OP_OR:   begin dec.ctrl.exe_cmd = EXE_OR;  dec.ctrl.wb_en = 1'b1; end
            OP_NOR:  begin dec.ctrl.exe_cmd = EXE_NOR; dec.ctrl.wb_en = 1'b1; end
            OP_XOR:  begin dec.ctrl.exe_cmd = EXE_XOR; dec.ctrl.wb_en = 1'b1; end
            OP_SLA,
            OP_SLL:  begin dec.ctrl.exe_cmd = EXE_SHL; dec.ctrl.wb_en = 1'b1; end
            OP_SRA:  begin dec.ctrl.exe_cmd = EXE_SRA; dec.ctrl.wb_en = 1'b1; end
            OP_SRL:  begin dec.ctrl.exe_cmd = EXE_SRL; dec.ctrl.wb_en = 1'b1; end
            OP_ADDI: begin dec.is_immediate = 1'b1; dec.ctrl.exe_cmd = EXE_ADD; dec.ctrl.wb_en = 1'b1; end
            OP_SUBI: begin dec.is_immediate = 1'b1; dec.ctrl.exe_cmd = EXE_SUB; dec.ctrl.wb_en = 1'b1; end
            OP_LD: begin
                dec.is_immediate  = 1'b1;
                dec.ctrl.exe_cmd  = EXE_ADD;
                dec.ctrl.mem_r_en = 1'b1;
                dec.ctrl.wb_en    = 1'b1;
            end
            OP_ST: begin
                dec.is_immediate  = 1'b1;
                dec.st_or_bne     = 1'b1;
                dec.ctrl.exe_cmd  = EXE_ADD;
                dec.ctrl.mem_w_en = 1'b1;
            end
            OP_BEZ: begin
                dec.is_immediate      = 1'b1;
                dec.is_branch_or_jump = 1'b1;
                dec.branch_type       = BR_BEZ;
            end
            OP_BNE: begin
                dec.is_immediate      = 1'b1;
                dec.st_or_bne         = 1'b1;
                dec.is_branch_or_jump = 1'b1;
                dec.branch_type       = BR_BNE;
            end
            OP_JMP: begin
                dec.is_immediate      = 1'b1;
                dec.is_branch_or_jump = 1'b1;
                dec.branch_type       = BR_JMP;
            end
            default: ;
        endcase
    end

    assign use_src1 = (opcode != OP_NOP) && (opcode != OP_JMP);
    assign use_src2 = ~dec.is_immediate | dec.st_or_bne;

    id_hazard_unit #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
        .in_valid     (in_valid),
        .src1         (src1),
        .src2         (src2),
        .use_src1     (use_src1),
        .use_src2     (use_src2),
        .is_branch    (dec.is_branch_or_jump),
        .EXE_dest     (EXE_dest),
        .MEM_dest     (MEM_dest),
        .EXE_WB_en    (EXE_WB_en),
        .EXE_MEM_R_en (EXE_MEM_R_en),
        .MEM_WB_en    (MEM_WB_en),
        .hazard       (hazard)
    );

    assign advance  = exe_ready | ~valid_q;
    assign in_ready = advance & ~hazard & ~flush;

    always_comb begin
        cond = 1'b0;
        case (dec.branch_type)
            BR_JMP:  cond = 1'b1;
            BR_BEZ:  cond = (Reg1 == '0);
            BR_BNE:  cond = (Reg1 != Reg2);
            default: cond = 1'b0;
        endcase
    end

    assign Br_taken = in_valid & in_ready & dec.is_branch_or_jump & cond;

    assign imm_ext     = {{(DATA_W-16){instruction[15]}}, instruction[15:0]};
    assign val2_d      = dec.is_immediate ? imm_ext : Reg2;
    assign valid_d     = in_valid & ~hazard & ~flush;
    assign ctrl_d      = valid_d ? dec.ctrl : '0;
    assign stall_inc   = hazard & ~flush & ~(&stall_cnt);
    assign stall_cnt_d = stall_cnt + CNT_W'(1);

`ifdef ID_FORWARDING_EN
    assign src1_fwd_d = src1;
    assign src2_fwd_d = src2;
`else
    assign src1_fwd_d = '0;
    assign src2_fwd_d = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            EXE_cmd_q  <= '0;
            MEM_R_en_q <= 1'b0;
            MEM_W_en_q <= 1'b0;
            WB_en_q    <= 1'b0;
            dest_q     <= '0;
            src1_q     <= '0;
            src2_q     <= '0;
            Val1_q     <= '0;
            Val2_q     <= '0;
            Reg2_q     <= '0;
            stall_cnt  <= '0;
        end else begin
            // Flush only kills validity/control; payload follows the normal advance rule.
            if (flush) begin
                valid_q    <= 1'b0;
                EXE_cmd_q  <= '0;
                MEM_R_en_q <= 1'b0;
                MEM_W_en_q <= 1'b0;
                WB_en_q    <= 1'b0;
            end else if (advance) begin
                valid_q    <= valid_d;
                EXE_cmd_q  <= ctrl_d.exe_cmd;
                MEM_R_en_q <= ctrl_d.mem_r_en;
                MEM_W_en_q <= ctrl_d.mem_w_en;
                WB_en_q    <= ctrl_d.wb_en;
            end
            if (advance) begin
                dest_q <= dest_f;
                src1_q <= src1_fwd_d;
                src2_q <= src2_fwd_d;
                Val1_q <= Reg1;
                Val2_q <= val2_d;
                Reg2_q <= Reg2;
            end
            if (stall_inc) begin
                stall_cnt <= stall_cnt_d;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: vector table for decode/datapath, hand
// sequences for hazards, back-pressure, flush and asynchronous reset.
module tb_id_stage_pipe;
    import id_stage_pipe_pkg::*;

`ifdef ID_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction;
    logic        in_valid, in_ready;
    logic [4:0]  src1, src2;
    logic [31:0] Reg1, Reg2;
    logic [4:0]  EXE_dest, MEM_dest;
    logic        EXE_WB_en, EXE_MEM_R_en, MEM_WB_en, exe_ready, flush, Br_taken;
    logic        valid_q;
    logic [4:0]  dest_q, src1_q, src2_q;
    logic [31:0] Val1_q, Val2_q, Reg2_q;
    logic [3:0]  EXE_cmd_q;
    logic        MEM_R_en_q, MEM_W_en_q, WB_en_q;
    logic [15:0] stall_cnt;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_stall = 0;

    always #5 clk = ~clk;

    id_stage_pipe dut (
        .clk(clk), .rst(rst), .instruction(instruction), .in_valid(in_valid), .in_ready(in_ready),
        .src1(src1), .src2(src2), .Reg1(Reg1), .Reg2(Reg2), .EXE_dest(EXE_dest), .MEM_dest(MEM_dest),
        .EXE_WB_en(EXE_WB_en), .EXE_MEM_R_en(EXE_MEM_R_en), .MEM_WB_en(MEM_WB_en),
        .exe_ready(exe_ready), .flush(flush), .Br_taken(Br_taken), .valid_q(valid_q),
        .dest_q(dest_q), .src1_q(src1_q), .src2_q(src2_q), .Val1_q(Val1_q), .Val2_q(Val2_q),
        .Reg2_q(Reg2_q), .EXE_cmd_q(EXE_cmd_q), .MEM_R_en_q(MEM_R_en_q), .MEM_W_en_q(MEM_W_en_q),
        .WB_en_q(WB_en_q), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic [31:0] instr;
        logic        vld;
        logic [31:0] r1, r2;
        logic        e_rdy, e_br;
        logic [4:0]  e_s1, e_s2;
        logic        e_vld;
        logic [31:0] e_v1, e_v2, e_r2;
        logic [3:0]  e_cmd;
        logic        e_mr, e_mw, e_wb;
        logic [4:0]  e_dest;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [31:0] enc_r(logic [5:0] op, logic [4:0] d, logic [4:0] s1, logic [4:0] s2);
        return {op, d, s1, s2, 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] d, logic [4:0] s1, logic [15:0] imm);
        return {op, d, s1, imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        instruction  = 32'd0;
        in_valid     = 1'b0;
        Reg1         = 32'd0;
        Reg2         = 32'd0;
        EXE_dest     = 5'd0;
        MEM_dest     = 5'd0;
        EXE_WB_en    = 1'b0;
        EXE_MEM_R_en = 1'b0;
        MEM_WB_en    = 1'b0;
        exe_ready    = 1'b1;
        flush        = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{enc_i(OP_ADDI, 5'd2, 5'd1, 16'd5), 1'b1, 32'd7, 32'h99, 1'b1, 1'b0, 5'd1, 5'd0,
                     1'b1, 32'd7, 32'd5, 32'h99, EXE_ADD, 1'b0, 1'b0, 1'b1, 5'd2};
        vecs[1]  = '{enc_i(OP_SUBI, 5'd4, 5'd5, 16'hFFFC), 1'b1, 32'd10, 32'd3, 1'b1, 1'b0, 5'd5, 5'd31,
                     1'b1, 32'd10, 32'hFFFFFFFC, 32'd3, EXE_SUB, 1'b0, 1'b0, 1'b1, 5'd4};
        vecs[2]  = '{enc_r(OP_ADD, 5'd3, 5'd6, 5'd7), 1'b1, 32'd100, 32'd23, 1'b1, 1'b0, 5'd6, 5'd7,
                     1'b1, 32'd100, 32'd23, 32'd23, EXE_ADD, 1'b0, 1'b0, 1'b1, 5'd3};
        vecs[3]  = '{enc_i(OP_LD, 5'd8, 5'd9, 16'h0010), 1'b1, 32'h1000, 32'd0, 1'b1, 1'b0, 5'd9, 5'd0,
                     1'b1, 32'h1000, 32'h10, 32'd0, EXE_ADD, 1'b1, 1'b0, 1'b1, 5'd8};
        vecs[4]  = '{enc_i(OP_ST, 5'd10, 5'd11, 16'h8000), 1'b1, 32'h20, 32'hABCD, 1'b1, 1'b0, 5'd11, 5'd10,
                     1'b1, 32'h20, 32'hFFFF8000, 32'hABCD, EXE_ADD, 1'b0, 1'b1, 1'b0, 5'd10};
        vecs[5]  = '{enc_i(OP_BNE, 5'd4, 5'd1, 16'd2), 1'b1, 32'd4, 32'd4, 1'b1, 1'b0, 5'd1, 5'd4,
                     1'b1, 32'd4, 32'd2, 32'd4, EXE_NOP, 1'b0, 1'b0, 1'b0, 5'd4};
        vecs[6]  = '{enc_i(OP_BNE, 5'd4, 5'd1, 16'd2), 1'b1, 32'd4, 32'd5, 1'b1, 1'b1, 5'd1, 5'd4,
                     1'b1, 32'd4, 32'd2, 32'd5, EXE_NOP, 1'b0, 1'b0, 1'b0, 5'd4};
        vecs[7]  = '{enc_i(OP_BEZ, 5'd0, 5'd2, 16'd3), 1'b1, 32'd0, 32'd7, 1'b1, 1'b1, 5'd2, 5'd0,
                     1'b1, 32'd0, 32'd3, 32'd7, EXE_NOP, 1'b0, 1'b0, 1'b0, 5'd0};
        vecs[8]  = '{enc_i(OP_BEZ, 5'd0, 5'd2, 16'd3), 1'b1, 32'd1, 32'd7, 1'b1, 1'b0, 5'd2, 5'd0,
                     1'b1, 32'd1, 32'd3, 32'd7, EXE_NOP, 1'b0, 1'b0, 1'b0, 5'd0};
        vecs[9]  = '{enc_i(OP_JMP, 5'd0, 5'd0, 16'h0040), 1'b1, 32'h55, 32'h66, 1'b1, 1'b1, 5'd0, 5'd0,
                     1'b1, 32'h55, 32'h40, 32'h66, EXE_NOP, 1'b0, 1'b0, 1'b0, 5'd0};
        vecs[10] = '{enc_r(OP_ADD, 5'd3, 5'd6, 5'd7), 1'b0, 32'd1, 32'd2, 1'b1, 1'b0, 5'd6, 5'd7,
                     1'b0, 32'd1, 32'd2, 32'd2, EXE_NOP, 1'b0, 1'b0, 1'b0, 5'd3};
        vecs[11] = '{enc_r(OP_XOR, 5'd1, 5'd2, 5'd3), 1'b1, 32'hF0, 32'h0F, 1'b1, 1'b0, 5'd2, 5'd3,
                     1'b1, 32'hF0, 32'h0F, 32'h0F, EXE_XOR, 1'b0, 1'b0, 1'b1, 5'd1};
        vecs[12] = '{enc_i(OP_JMP, 5'd0, 5'd0, 16'h0040), 1'b0, 32'h1, 32'h2, 1'b1, 1'b0, 5'd0, 5'd0,
                     1'b0, 32'h1, 32'h40, 32'h2, EXE_NOP, 1'b0, 1'b0, 1'b0, 5'd0};

        // Reset state
        idle_inputs();
        rst = 1'b1;
        #12;
        chk("rst_valid", {31'd0, valid_q}, 32'd0);
        chk("rst_wb", {31'd0, WB_en_q}, 32'd0);
        chk("rst_val1", Val1_q, 32'd0);
        chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
        tick();
        rst = 1'b0;

        // Table-driven decode and datapath
        for (int i = 0; i < 13; i++) begin
            instruction = vecs[i].instr;
            in_valid    = vecs[i].vld;
            Reg1        = vecs[i].r1;
            Reg2        = vecs[i].r2;
            @(negedge clk);
            chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].e_rdy});
            chk($sformatf("v%0d_br", i), {31'd0, Br_taken}, {31'd0, vecs[i].e_br});
            chk($sformatf("v%0d_src1", i), {27'd0, src1}, {27'd0, vecs[i].e_s1});
            chk($sformatf("v%0d_src2", i), {27'd0, src2}, {27'd0, vecs[i].e_s2});
            tick();
            chk($sformatf("v%0d_valid", i), {31'd0, valid_q}, {31'd0, vecs[i].e_vld});
            chk($sformatf("v%0d_val1", i), Val1_q, vecs[i].e_v1);
            chk($sformatf("v%0d_val2", i), Val2_q, vecs[i].e_v2);
            chk($sformatf("v%0d_reg2", i), Reg2_q, vecs[i].e_r2);
            chk($sformatf("v%0d_cmd", i), {28'd0, EXE_cmd_q}, {28'd0, vecs[i].e_cmd});
            chk($sformatf("v%0d_ctrl", i), {29'd0, MEM_R_en_q, MEM_W_en_q, WB_en_q},
                {29'd0, vecs[i].e_mr, vecs[i].e_mw, vecs[i].e_wb});
            chk($sformatf("v%0d_dest", i), {27'd0, dest_q}, {27'd0, vecs[i].e_dest});
            chk($sformatf("v%0d_src1q", i), {27'd0, src1_q}, FWD ? {27'd0, vecs[i].e_s1} : 32'd0);
            chk($sformatf("v%0d_src2q", i), {27'd0, src2_q}, FWD ? {27'd0, vecs[i].e_s2} : 32'd0);
            $display("vec %0d instr=%08h in_ready=%0b br=%0b valid_q=%0b", i, vecs[i].instr, in_ready, Br_taken, valid_q);
        end

        // Load-use: stall in both hazard rules, bubble inserted
        idle_inputs();
        instruction = enc_r(OP_ADD, 5'd5, 5'd3, 5'd4);
        in_valid = 1'b1;
        EXE_dest = 5'd3; EXE_MEM_R_en = 1'b1; EXE_WB_en = 1'b1;
        @(negedge clk);
        chk("lu_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        exp_stall++;
        chk("lu_bubble_valid", {31'd0, valid_q}, 32'd0);
        chk("lu_bubble_ctrl", {25'd0, EXE_cmd_q, MEM_R_en_q, MEM_W_en_q, WB_en_q}, 32'd0);
        chk("lu_stall_cnt", {16'd0, stall_cnt}, exp_stall);
        EXE_dest = 5'd0; EXE_MEM_R_en = 1'b0; EXE_WB_en = 1'b0;
        @(negedge clk);
        chk("lu_clear_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("lu_accept_valid", {31'd0, valid_q}, 32'd1);
        chk("lu_accept_wb", {31'd0, WB_en_q}, 32'd1);
        chk("lu_stall_hold", {16'd0, stall_cnt}, exp_stall);
        $display("seq load-use stall_cnt=%0d", stall_cnt);

        // ALU result in EXE, then in MEM: forwarding avoids the stall
        for (int k = 0; k < 2; k++) begin
            EXE_dest = (k == 0) ? 5'd3 : 5'd0;
            EXE_WB_en = (k == 0);
            MEM_dest = (k == 1) ? 5'd3 : 5'd0;
            MEM_WB_en = (k == 1);
            @(negedge clk);
            chk($sformatf("alu%0d_ready", k), {31'd0, in_ready}, FWD ? 32'd1 : 32'd0);
            tick();
            if (!FWD) exp_stall++;
            chk($sformatf("alu%0d_valid", k), {31'd0, valid_q}, FWD ? 32'd1 : 32'd0);
            chk($sformatf("alu%0d_stall", k), {16'd0, stall_cnt}, exp_stall);
            $display("seq alu-dep %0d in_ready=%0b stall_cnt=%0d", k, in_ready, stall_cnt);
        end

        // Branch operand produced in EXE: stalls under both rules, no redirect
        idle_inputs();
        instruction = enc_i(OP_BEZ, 5'd0, 5'd6, 16'd8);
        in_valid = 1'b1; Reg1 = 32'd0;
        EXE_dest = 5'd6; EXE_WB_en = 1'b1;
        @(negedge clk);
        chk("brh_ready", {31'd0, in_ready}, 32'd0);
        chk("brh_br", {31'd0, Br_taken}, 32'd0);
        tick();
        exp_stall++;
        chk("brh_stall", {16'd0, stall_cnt}, exp_stall);

        // r0 never creates a dependency
        idle_inputs();
        instruction = enc_r(OP_ADD, 5'd5, 5'd0, 5'd4);
        in_valid = 1'b1;
        EXE_dest = 5'd0; EXE_WB_en = 1'b1; EXE_MEM_R_en = 1'b1;
        @(negedge clk);
        chk("r0_ready", {31'd0, in_ready}, 32'd1);
        tick();
        $display("seq r0 valid_q=%0b", valid_q);

        // Back-pressure: hold for 3 cycles, then flush
        idle_inputs();
        instruction = enc_i(OP_ADDI, 5'd2, 5'd1, 16'd5);
        in_valid = 1'b1; Reg1 = 32'd7;
        tick();
        exe_ready = 1'b0;
        instruction = enc_r(OP_SUB, 5'd9, 5'd8, 5'd7);
        Reg1 = 32'h77; Reg2 = 32'h88;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_ready", k), {31'd0, in_ready}, 32'd0);
            tick();
            chk($sformatf("hold%0d_valid", k), {31'd0, valid_q}, 32'd1);
            chk($sformatf("hold%0d_val1", k), Val1_q, 32'd7);
            chk($sformatf("hold%0d_val2", k), Val2_q, 32'd5);
            chk($sformatf("hold%0d_dest", k), {27'd0, dest_q}, 32'd2);
            chk($sformatf("hold%0d_cmd", k), {28'd0, EXE_cmd_q}, {28'd0, EXE_ADD});
            $display("seq hold %0d valid_q=%0b Val1_q=%0h", k, valid_q, Val1_q);
        end
        instruction = enc_i(OP_JMP, 5'd0, 5'd0, 16'h10);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_br", {31'd0, Br_taken}, 32'd0);
        tick();
        chk("flush_valid", {31'd0, valid_q}, 32'd0);
        chk("flush_wb", {31'd0, WB_en_q}, 32'd0);
        $display("seq flush valid_q=%0b", valid_q);

        // Asynchronous reset in the middle of a stall
        idle_inputs();
        instruction = enc_i(OP_ADDI, 5'd2, 5'd1, 16'd5);
        in_valid = 1'b1; Reg1 = 32'd7;
        tick();
        exe_ready = 1'b0;
        EXE_dest = 5'd1; EXE_WB_en = 1'b1; EXE_MEM_R_en = 1'b1;
        tick();
        exp_stall++;
        chk("pre_rst_valid", {31'd0, valid_q}, 32'd1);
        chk("pre_rst_stall", {16'd0, stall_cnt}, exp_stall);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, valid_q}, 32'd0);
        chk("arst_val1", Val1_q, 32'd0);
        chk("arst_val2", Val2_q, 32'd0);
        chk("arst_ctrl", {25'd0, EXE_cmd_q, MEM_R_en_q, MEM_W_en_q, WB_en_q}, 32'd0);
        chk("arst_dest", {27'd0, dest_q}, 32'd0);
        chk("arst_stall", {16'd0, stall_cnt}, 32'd0);
        #2;
        rst = 1'b0;
        idle_inputs();
        instruction = enc_i(OP_ADDI, 5'd2, 5'd1, 16'd5);
        in_valid = 1'b1; Reg1 = 32'd7;
        tick();
        chk("post_rst_valid", {31'd0, valid_q}, 32'd1);
        chk("post_rst_val1", Val1_q, 32'd7);
        $display("seq async reset, post-reset valid_q=%0b", valid_q);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
